// File: rtl/pwm_shift_sequencer.sv
// rtl/pwm_shift_sequencer.sv - serial PWM sequencer for an external shift register with output latch
module pwm_shift_sequencer #(
   parameter int CHANNELS = 8,
   parameter int CNT_W    = 8,
   parameter int PERIOD   = 100
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        en,
   input  logic                        cfg_valid,
   output logic                        cfg_ready,
   input  logic [$clog2(CHANNELS)-1:0] cfg_chan,
   input  logic [CNT_W-1:0]            cfg_duty,
   input  logic                        cfg_commit,
   output logic                        sr_data,
   output logic                        sr_clk,
   output logic                        sr_latch,
   output logic                        period_done,
   output logic                        busy
);

   localparam int IDX_W = $clog2(CHANNELS);
   localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(CHANNELS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT_HI, LATCH} state_t;

   state_t           state;
   logic [CNT_W-1:0] counter;
   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] shadow [CHANNELS];
   logic [CNT_W-1:0] active [CHANNELS];
   logic             commit_pending;

   logic             cfg_accept;
   logic             wrap;
   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W-1:0] top_duty_next;
   logic [CNT_W-1:0] idle_top_duty;
   logic [CNT_W-1:0] next_idx_duty;

   // Duties the first SETUP of the coming step will see, including a transfer landing on the same edge
   always_comb begin
      cfg_accept    = cfg_valid & ~commit_pending;
      wrap          = (counter == CNT_LAST);
      cnt_next      = wrap ? '0 : counter + 1'b1;
      top_duty_next = (wrap && commit_pending) ? shadow[IDX_TOP] : active[IDX_TOP];
      idle_top_duty = commit_pending ? shadow[IDX_TOP] : active[IDX_TOP];
      next_idx_duty = active[idx - 1'b1];
   end

   assign cfg_ready = ~commit_pending;

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         counter        <= '0;
         idx            <= IDX_TOP;
         commit_pending <= 1'b0;
         sr_data        <= 1'b0;
         sr_clk         <= 1'b0;
         sr_latch       <= 1'b0;
         period_done    <= 1'b0;
         busy           <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (commit_pending) begin
                  active         <= shadow;
                  commit_pending <= 1'b0;
               end
               if (en) begin
                  state   <= SETUP;
                  busy    <= 1'b1;
                  sr_data <= (counter < idle_top_duty);
               end
            end
            SETUP: begin
               state  <= SHIFT_HI;
               sr_clk <= 1'b1;
            end
            SHIFT_HI: begin
               sr_clk <= 1'b0;
               if (idx == '0) begin
                  state       <= LATCH;
                  sr_latch    <= 1'b1;
                  sr_data     <= 1'b0;
                  idx         <= IDX_TOP;
                  period_done <= wrap;
               end else begin
                  state   <= SETUP;
                  idx     <= idx - 1'b1;
                  sr_data <= (counter < next_idx_duty);
               end
            end
            LATCH: begin
               sr_latch    <= 1'b0;
               period_done <= 1'b0;
               counter     <= cnt_next;
               if (wrap && commit_pending) begin
                  active         <= shadow;
                  commit_pending <= 1'b0;
               end
               if (en) begin
                  state   <= SETUP;
                  sr_data <= (cnt_next < top_duty_next);
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase

         // Accept only happens with nothing pending, so it never races the transfer clear above
         if (cfg_accept) begin
            if (int'(cfg_chan) < CHANNELS) shadow[cfg_chan] <= cfg_duty;
            if (cfg_commit) commit_pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pwm_shift_sequencer.sv
// tb/tb_pwm_shift_sequencer.sv - randomized step-level model bench for pwm_shift_sequencer
module tb_pwm_shift_sequencer;
   localparam int CHANNELS = 8;
   localparam int CNT_W    = 8;
   localparam int PERIOD   = 100;

   logic clk = 1'b0;
   logic reset, en, cfg_valid, cfg_ready, cfg_commit;
   logic sr_data, sr_clk, sr_latch, period_done, busy;
   logic [2:0] cfg_chan;
   logic [7:0] cfg_duty;

   always #5 clk = ~clk;

   pwm_shift_sequencer #(.CHANNELS(CHANNELS), .CNT_W(CNT_W), .PERIOD(PERIOD)) dut (
      .clk(clk), .reset(reset), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_chan(cfg_chan), .cfg_duty(cfg_duty), .cfg_commit(cfg_commit),
      .sr_data(sr_data), .sr_clk(sr_clk), .sr_latch(sr_latch),
      .period_done(period_done), .busy(busy)
   );

   int tests = 0;
   int fails = 0;

   // External shift register + output latch, plus protocol watch
   logic [7:0] sreg = 8'h00;
   logic [7:0] latched = 8'h00;
   int latch_cnt = 0, pd_cnt = 0, proto_err = 0;
   logic prev_clk = 1'b0, prev_data = 1'b0;

   always @(negedge clk) begin
      if (sr_clk === 1'b1 && prev_clk === 1'b0) begin
         if (sr_data !== prev_data) proto_err++;
         sreg = {sreg[6:0], sr_data};
      end
      if (sr_latch === 1'b1) begin
         latched = sreg;
         latch_cnt++;
      end
      if (sr_clk === 1'b1 && sr_latch === 1'b1) proto_err++;
      if (period_done === 1'b1) begin
         pd_cnt++;
         if (sr_latch !== 1'b1) proto_err++;
      end
      prev_clk  = sr_clk;
      prev_data = sr_data;
   end

   // Step-level reference model
   int m_active[CHANNELS];
   int m_shadow[CHANNELS];
   bit m_pending;
   int m_counter;

   task automatic model_reset();
      for (int i = 0; i < CHANNELS; i++) begin
         m_active[i] = 0;
         m_shadow[i] = 0;
      end
      m_pending = 0;
      m_counter = 0;
   endtask

   task automatic advance_model(output logic [7:0] exp, output bit wrap);
      for (int i = 0; i < CHANNELS; i++) exp[i] = (m_counter < m_active[i]);
      wrap = (m_counter == PERIOD - 1);
      if (wrap) begin
         m_counter = 0;
         if (m_pending) begin
            m_active  = m_shadow;
            m_pending = 0;
         end
      end else begin
         m_counter++;
      end
   endtask

   task automatic model_idle_commit();
      if (m_pending) begin
         m_active  = m_shadow;
         m_pending = 0;
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_latch(output bit ok, output int cyc);
      int n0;
      n0  = latch_cnt;
      cyc = 0;
      while (latch_cnt == n0 && cyc < 60) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      ok = (latch_cnt != n0);
   endtask

   task automatic cfg_write(input int chan, input int duty, input bit commit);
      cfg_valid  = 1'b1;
      cfg_chan   = chan[2:0];
      cfg_duty   = duty[7:0];
      cfg_commit = commit;
      @(posedge clk);
      #1;
      cfg_valid  = 1'b0;
      cfg_commit = 1'b0;
      if (!m_pending) begin
         m_shadow[chan] = duty;
         if (commit) m_pending = 1;
      end
   endtask

   function automatic int rand_duty();
      case ($urandom_range(0, 3))
         0:       return 0;
         1:       return int'($urandom_range(1, PERIOD - 1));
         2:       return int'($urandom_range(PERIOD, 255));
         default: return int'($urandom_range(0, 255));
      endcase
   endfunction

   task automatic test_reset();
      int n0;
      reset = 1'b1; en = 1'b0;
      tick(3);
      reset = 1'b0; en = 1'b1;
      tick(10);
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick(1);
         tests++;
         if ({sr_data, sr_clk, sr_latch, period_done, busy, cfg_ready} !== 6'b000001) begin
            fails++;
            $display("FAIL reset_outputs cycle %0d: got %b want 000001", c,
                     {sr_data, sr_clk, sr_latch, period_done, busy, cfg_ready});
         end
      end
      reset = 1'b0; en = 1'b0;
      n0 = latch_cnt;
      tick(20);
      tests++;
      if (latched !== 8'h00 || latch_cnt != n0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_idle: latched=%h latches=%0d busy=%b want 00/0/0", latched, latch_cnt - n0, busy);
      end
      model_reset();
   endtask

   task automatic test_single_step();
      logic [7:0] exp, dbits;
      bit wrap;
      int pulses, latch_at, nlatch;
      cfg_write(0, 100, 1);
      tick(2);
      model_idle_commit();
      tests++;
      if (cfg_ready !== 1'b1) begin
         fails++;
         $display("FAIL idle_commit_ready: got %b want 1", cfg_ready);
      end
      pulses = 0; latch_at = 0; nlatch = 0; dbits = 8'h00;
      en = 1'b1;
      for (int c = 1; c <= 17; c++) begin
         tick(1);
         if (sr_clk === 1'b1) begin
            pulses++;
            dbits = {dbits[6:0], sr_data};
         end
         if (sr_latch === 1'b1) begin
            latch_at = c;
            nlatch++;
         end
         if (c == 17) en = 1'b0;
      end
      tick(1);
      advance_model(exp, wrap);
      tests++;
      if (pulses != 8 || nlatch != 1 || latch_at != 17) begin
         fails++;
         $display("FAIL single_step_timing: pulses=%0d latches=%0d at=%0d want 8/1/17", pulses, nlatch, latch_at);
      end
      tests++;
      if (dbits !== exp || latched !== 8'h01) begin
         fails++;
         $display("FAIL single_step_data: bits=%h latched=%h want %h/01", dbits, latched, exp);
      end
   endtask

   task automatic test_full_period();
      logic [7:0] exp;
      bit wrap, ok;
      int cyc, cyc_sum, pd0;
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 7; i++) cfg_write(i, 10 * (i + 1), 0);
      cfg_write(7, 80, 1);
      tick(2);
      model_idle_commit();
      en = 1'b1;
      cyc_sum = 0;
      pd0 = pd_cnt;
      for (int s = 0; s <= PERIOD; s++) begin
         wait_latch(ok, cyc);
         tests++;
         if (!ok) begin
            fails++;
            $display("FAIL full_period_timeout step %0d: no latch within %0d cycles", s, cyc);
            break;
         end
         if (s > 0) cyc_sum += cyc;
         advance_model(exp, wrap);
         tests++;
         if (latched !== exp) begin
            fails++;
            $display("FAIL full_period_step %0d: got %h want %h", s, latched, exp);
         end
         if (s == 0 || s == 45 || s == 85) begin
            tests++;
            if (latched !== ((s == 0) ? 8'hFF : (s == 45) ? 8'hF0 : 8'h00)) begin
               fails++;
               $display("FAIL full_period_fixed step %0d: got %h", s, latched);
            end
         end
      end
      tests++;
      if (pd_cnt - pd0 != 1 || cyc_sum != PERIOD * (2 * CHANNELS + 1)) begin
         fails++;
         $display("FAIL period_length: period_done=%0d cycles=%0d want 1/%0d", pd_cnt - pd0, cyc_sum,
                  PERIOD * (2 * CHANNELS + 1));
      end
   endtask

   task automatic test_commit_handshake();
      logic [7:0] exp;
      bit wrap, ok, seen_wrap;
      int cyc;
      for (int n = 0; n < 200 && m_counter != 30; n++) begin
         wait_latch(ok, cyc);
         advance_model(exp, wrap);
         tests++;
         if (!ok || latched !== exp) begin
            fails++;
            $display("FAIL pre_commit_step: got %h want %h ok=%0d", latched, exp, ok);
         end
      end
      cfg_write(3, 55, 1);
      tests++;
      if (cfg_ready !== 1'b0) begin
         fails++;
         $display("FAIL commit_ready_low: got %b want 0", cfg_ready);
      end
      cfg_write(1, 77, 0);
      tests++;
      if (cfg_ready !== 1'b0) begin
         fails++;
         $display("FAIL pending_ready_low: got %b want 0", cfg_ready);
      end
      seen_wrap = 0;
      for (int n = 0; n < 200 && !(seen_wrap && m_counter == 51); n++) begin
         wait_latch(ok, cyc);
         advance_model(exp, wrap);
         if (wrap) seen_wrap = 1;
         tests++;
         if (!ok || latched !== exp || cfg_ready !== !m_pending) begin
            fails++;
            $display("FAIL commit_step %0d: got %h ready=%b want %h ready=%b", m_counter - 1, latched,
                     cfg_ready, exp, !m_pending);
         end
      end
      tests++;
      if (latched !== 8'hE8) begin
         fails++;
         $display("FAIL commit_new_duty step 50: got %h want e8", latched);
      end
      cfg_write(7, 80, 1);
      seen_wrap = 0;
      for (int n = 0; n < 200 && !(seen_wrap && m_counter == 26); n++) begin
         wait_latch(ok, cyc);
         advance_model(exp, wrap);
         if (wrap) seen_wrap = 1;
         tests++;
         if (!ok || latched !== exp) begin
            fails++;
            $display("FAIL recommit_step: got %h want %h ok=%0d", latched, exp, ok);
         end
      end
      tests++;
      if (latched !== 8'hFC) begin
         fails++;
         $display("FAIL ignored_write step 25: got %h want fc", latched);
      end
   endtask

   task automatic test_enable_drop();
      logic [7:0] exp;
      bit wrap, ok;
      int cyc, n0;
      en = 1'b0;
      tick(20);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      model_reset();
      cfg_write(0, 13, 0);
      cfg_write(1, 14, 0);
      cfg_write(2, 12, 1);
      tick(2);
      model_idle_commit();
      en = 1'b1;
      for (int s = 0; s < 12; s++) begin
         wait_latch(ok, cyc);
         advance_model(exp, wrap);
         tests++;
         if (!ok || latched !== exp) begin
            fails++;
            $display("FAIL drop_prefix step %0d: got %h want %h", s, latched, exp);
         end
      end
      tick(8);
      en = 1'b0;
      wait_latch(ok, cyc);
      advance_model(exp, wrap);
      tests++;
      if (!ok || latched !== exp || latched !== 8'h03) begin
         fails++;
         $display("FAIL drop_step12: got %h want %h", latched, exp);
      end
      tick(2);
      n0 = latch_cnt;
      tick(20);
      tests++;
      if (busy !== 1'b0 || latch_cnt != n0) begin
         fails++;
         $display("FAIL drop_idle: busy=%b extra_latches=%0d want 0/0", busy, latch_cnt - n0);
      end
      en = 1'b1;
      wait_latch(ok, cyc);
      advance_model(exp, wrap);
      tests++;
      if (!ok || latched !== exp || latched !== 8'h02) begin
         fails++;
         $display("FAIL resume_step13: got %h want %h", latched, exp);
      end
   endtask

   task automatic test_reset_mid_shift();
      logic [7:0] exp;
      bit wrap, ok;
      int cyc, n0;
      tick(9);
      tests++;
      if (sr_clk !== 1'b1) begin
         fails++;
         $display("FAIL fifth_shift_hi: sr_clk=%b want 1", sr_clk);
      end
      n0 = latch_cnt;
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      en = 1'b0;
      model_reset();
      tick(30);
      tests++;
      if (latch_cnt != n0 || {busy, sr_clk, sr_latch, cfg_ready} !== 4'b0001) begin
         fails++;
         $display("FAIL reset_abort: latches=%0d outs=%b want 0/0001", latch_cnt - n0,
                  {busy, sr_clk, sr_latch, cfg_ready});
      end
      cfg_write(7, 1, 1);
      tick(2);
      model_idle_commit();
      en = 1'b1;
      wait_latch(ok, cyc);
      advance_model(exp, wrap);
      tests++;
      if (!ok || latched !== exp || latched !== 8'h80) begin
         fails++;
         $display("FAIL after_reset_step: got %h want %h", latched, exp);
      end
   endtask

   task automatic test_random();
      logic [7:0] exp;
      bit wrap, ok;
      int cyc, pd0;
      en = 1'b0;
      tick(20);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < CHANNELS; i++) cfg_write(i, rand_duty(), i == CHANNELS - 1);
      tick(2);
      model_idle_commit();
      en = 1'b1;
      for (int s = 0; s < 300; s++) begin
         pd0 = pd_cnt;
         wait_latch(ok, cyc);
         advance_model(exp, wrap);
         tests++;
         if (!ok || latched !== exp || (pd_cnt - pd0) != int'(wrap)) begin
            fails++;
            $display("FAIL random_step %0d: got %h pd=%0d want %h pd=%0d", s, latched, pd_cnt - pd0,
                     exp, wrap);
         end
         case ($urandom_range(0, 9))
            0, 1, 2: begin
               tests++;
               if (cfg_ready !== !m_pending) begin
                  fails++;
                  $display("FAIL random_ready: got %b want %b", cfg_ready, !m_pending);
               end
               cfg_write($urandom_range(0, CHANNELS - 1), rand_duty(), $urandom_range(0, 3) == 0);
            end
            9: begin
               en = 1'b0;
               pd0 = pd_cnt;
               wait_latch(ok, cyc);
               advance_model(exp, wrap);
               model_idle_commit();
               tests++;
               if (!ok || latched !== exp || (pd_cnt - pd0) != int'(wrap)) begin
                  fails++;
                  $display("FAIL random_drop_step: got %h want %h", latched, exp);
               end
               tick($urandom_range(1, 5));
               en = 1'b1;
            end
            default: ;
         endcase
      end
      tests++;
      if (proto_err != 0) begin
         fails++;
         $display("FAIL shift_protocol: %0d violations want 0", proto_err);
      end
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_commit = 1'b0;
      cfg_chan = 3'd0; cfg_duty = 8'd0;
      model_reset();
      test_reset();
      test_single_step();
      test_full_period();
      test_commit_handshake();
      test_enable_drop();
      test_reset_mid_shift();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pwm_shift_sequencer.md
# pwm_shift_sequencer

Sequencer that drives an 8-channel serial PWM output stage: an external or on-chip serial-in shift register with a separate output latch. For every PWM counter step, it serialises one bit per channel, with bit = (counter < duty[ch]), and then pulses the latch. Duty values are written through a valid/ready configuration port into a shadow bank. A committed shadow bank becomes active only at a PWM period boundary, so no latched frame ever mixes old and new duties.

## Interface
- CHANNELS, 8, number of PWM channels (bits shifted per step)
- CNT_W, 8, width of PWM counter and duty values
- PERIOD, 100, counter steps per PWM period (counter runs 0..PERIOD-1); 2 ≤ PERIOD ≤ 2^CNT_W

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- en  in  1  run enable
- cfg_valid  in  1  duty write request
- cfg_ready  out  1  write/commit may be accepted
- cfg_chan  in  $clog2(CHANNELS)  channel index for write
- cfg_duty  in  CNT_W  duty value for write
- cfg_commit  in  1  with cfg_valid: request shadow→active transfer at next period wrap
- sr_data  out  1  serial data to shift register
- sr_clk  out  1  shift clock; register samples on its rising edge
- sr_latch  out  1  one-cycle latch pulse: shift register → outputs
- period_done  out  1  one-cycle pulse on the latch of step PERIOD-1
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, SETUP, SHIFT_HI, LATCH. All outputs are decoded from flops, with no input-to-output combinational path.
- Reset:
  - State goes to IDLE; counter = 0; bit index = CHANNELS-1.
  - Shadow and active duties = 0; commit_pending = 0.
  - sr_data = sr_clk = sr_latch = period_done = busy = 0; cfg_ready = 1.
- IDLE → SETUP when en = 1.
- SETUP (1 cycle):
  - sr_data = (counter < active[idx]); sr_clk = 0.
  - Channel CHANNELS-1 is shifted first, so channel 0 ends in the register's bit 0.
- SHIFT_HI (1 cycle): sr_clk = 1 and sr_data is held.
  - If idx = 0: go to LATCH.
  - Otherwise idx decrements and the next state is SETUP.
- LATCH (1 cycle): sr_latch = 1, sr_clk = 0, idx reloads to CHANNELS-1.
  - If counter = PERIOD-1: counter ← 0 and period_done = 1. If commit_pending, active ← shadow (all channels) and commit_pending ← 0.
  - Otherwise counter increments.
  - Next state is SETUP if en = 1, else IDLE.
- Comparison is unsigned at CNT_W bits:
  - duty = 0 → channel always low.
  - duty ≥ PERIOD → channel always high.
- Config port:
  - A write is accepted when cfg_valid & cfg_ready; shadow[cfg_chan] ← cfg_duty. A cfg_chan ≥ CHANNELS is accepted and ignored.
  - cfg_commit on an accepted beat also writes that beat's duty and sets commit_pending.
  - cfg_ready = !commit_pending.
  - The shadow bank is never modified while a commit is pending.
- Idle commit: if state is IDLE with commit_pending, transfer occurs immediately in the next cycle, counter is unchanged, and there is no period_done.
- en deassert mid-step: the current step completes through LATCH, then the block enters IDLE with the counter value held. Re-enable resumes from that counter value.
- Reset mid-step: immediate abort with all reset values, and no latch pulse is issued.
- Commit and wrap in the same cycle: the commit is accepted, and transfer happens at the following wrap (not the current one).

## Timing
- Step length = 2·CHANNELS + 1 cycles (17 for the defaults).
- Period = PERIOD·(2·CHANNELS+1) cycles (1700 for the defaults).
- First SETUP occurs 1 cycle after en is seen high in IDLE.
- sr_data is stable one cycle before and during each sr_clk high cycle.
- sr_latch is high in the cycle after the last sr_clk high cycle, never coincident with sr_clk.
- Commit latency: active duties change at the first wrap after acceptance, up to one full period. cfg_ready returns high the cycle after the transfer.

## Test plan
- Reset: assert reset for 3 cycles while running → all outputs 0, cfg_ready = 1, busy = 0; the register's latched value stays 0 after release with en = 0.
- Single step: active ch0 = 100, others 0, en = 1 → 8 sr_clk pulses, sr_data high only on the 8th, sr_latch in cycle 17, latched byte 0x01.
- Full period: duties ch0..ch7 = 10, 20, …, 80, committed while IDLE → latched bit i at step k equals (k < 10·(i+1)); step 0 gives 0xFF, step 45 gives 0xF0, step 85 gives 0x00; exactly one period_done per 1700 cycles.
- Commit handshake: at step 30 write ch3 = 55 with commit → cfg_ready low until wrap; ch3 uses 40 through step 99 and 55 from step 0; a write attempted while pending is not accepted.
- Enable drop: deassert en during bit 3 of step 12 → step 12 latches normally, the block goes IDLE with busy = 0; re-enable → next latched step is 13.
- Reset mid-shift: reset during the 5th SHIFT_HI → no sr_latch; counter and duties return to 0; the shadow bank is cleared.
